// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run/launch controller.
package run_ctrl_pkg;

  // Run sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } run_state_e;

  // Widest entry-point vector and PC the helper below can handle.
  localparam int unsigned MaxVecW = 512;
  localparam int unsigned MaxPcW  = 32;

  // Pull entry point 'sel' (pc_w bits wide) out of a packed address vector.
  function automatic logic [MaxPcW-1:0] entry_addr(input logic [MaxVecW-1:0] base_vec,
                                                   input int unsigned        sel,
                                                   input int unsigned        pc_w);
    logic [MaxVecW-1:0] shifted;
    logic [MaxPcW-1:0]  addr;
    shifted = base_vec >> (sel * pc_w);
    addr    = '0;
    for (int unsigned b = 0; b < MaxPcW; b++) begin
      if (b < pc_w) addr[b] = shifted[b];
    end
    return addr;
  endfunction

endpackage

// File: rtl/run_ctrl_watchdog.sv
// Run-cycle counter, PC stall detector and timeout compare for run_ctrl.
module run_ctrl_watchdog
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = 7,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned TIMEOUT      = 2000,
  parameter int unsigned STALL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PC_W-1:0]  pc,
  output logic             stall_hit,
  output logic             tout_hit,
  output logic [CNT_W-1:0] cycle_count
);

  // Wide enough to hold STALL_CYCLES itself.
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  logic [CNT_W-1:0]   cycle_q;
  logic [STALL_W-1:0] stall_q;
  logic [PC_W-1:0]    prev_pc_q;
  logic               first_q;
  logic               same_pc;

  // prev_pc is stale on the first RUN cycle, so no comparison then.
  assign same_pc     = !first_q && (pc == prev_pc_q);
  assign stall_hit   = en && same_pc && (stall_q == STALL_W'(STALL_CYCLES - 1));
  assign tout_hit    = en && (cycle_q == CNT_W'(TIMEOUT - 1));
  assign cycle_count = cycle_q;

  // Counters clear on LOAD and advance only while running.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cycle_q   <= '0;
      stall_q   <= '0;
      prev_pc_q <= '0;
      first_q   <= 1'b1;
    end else if (en) begin
      cycle_q   <= cycle_q + CNT_W'(1);
      prev_pc_q <= pc;
      first_q   <= 1'b0;
      stall_q   <= same_pc ? stall_q + STALL_W'(1) : '0;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/launch controller: launches on start falling edge, holds the core in reset
// for one load cycle, runs until halt, PC stall or watchdog timeout.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned                  PC_W         = 7,
  parameter int unsigned                  INSTR_W      = 9,
  parameter int unsigned                  NUM_PROGS    = 4,
  parameter logic [NUM_PROGS*PC_W-1:0]    PROG_BASE    = {7'd96, 7'd64, 7'd32, 7'd0},
  parameter int unsigned                  CNT_W        = 12,
  parameter int unsigned                  TIMEOUT      = 2000,
  parameter logic [INSTR_W-1:0]           HALT_OP      = 9'b111000000,
  parameter logic [INSTR_W-1:0]           HALT_MASK    = 9'b111111111,
  parameter int unsigned                  STALL_CYCLES = 2,
  localparam int unsigned                 SEL_W        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEL_W-1:0]   prog_sel,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               core_rst,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               run_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [PC_W-1:0]    halt_pc
);

  run_state_e      state_q, state_d;
  logic            start_q;
  logic            launch;
  logic            halt_hit;
  logic            stall_hit;
  logic            tout_hit;
  logic            run_exit;
  logic [PC_W-1:0] pc_load_val_q;
  logic [PC_W-1:0] halt_pc_q;
  logic [PC_W-1:0] load_addr;
  int unsigned     sel_idx;

  assign launch   = start_q && !start;
  assign halt_hit = ((instr & HALT_MASK) == (HALT_OP & HALT_MASK));
  assign run_exit = (state_q == RUN) && (halt_hit || stall_hit || tout_hit) && !launch;

  // Out-of-range selections fall back to entry 0.
  always_comb begin
    sel_idx = 32'(prog_sel);
    if (sel_idx >= NUM_PROGS) sel_idx = 0;
    load_addr = PC_W'(entry_addr(MaxVecW'(PROG_BASE), sel_idx, PC_W));
  end

  // Next-state: launch overrides everything; RUN exits by halt > stall > timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      LOAD:    state_d = RUN;
      RUN: begin
        if (halt_hit)       state_d = DONE;
        else if (stall_hit) state_d = DONE;
        else if (tout_hit)  state_d = TOUT;
      end
      DONE:    state_d = DONE;
      TOUT:    state_d = TOUT;
      default: state_d = IDLE;
    endcase
    if (launch) state_d = LOAD;
  end

  // State, start edge detect, load value and halt PC capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      pc_load_val_q <= '0;
      halt_pc_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      if (launch) pc_load_val_q <= load_addr;
      if (state_q == LOAD) halt_pc_q <= '0;
      else if (run_exit)   halt_pc_q <= pc;
    end
  end

  run_ctrl_watchdog #(
    .PC_W         (PC_W),
    .CNT_W        (CNT_W),
    .TIMEOUT      (TIMEOUT),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .clr         (state_q == LOAD),
    .en          (state_q == RUN),
    .pc          (pc),
    .stall_hit   (stall_hit),
    .tout_hit    (tout_hit),
    .cycle_count (cycle_count)
  );

  assign core_rst    = reset || (state_q == LOAD);
  assign pc_load     = (state_q == LOAD);
  assign pc_load_val = pc_load_val_q;
  assign run_en      = (state_q == RUN);
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = (state_q == TOUT);
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: launch, halt, stall, timeout, relaunch, reset, clamp.
module tb_run_ctrl;

  localparam logic [8:0] HaltInstr = 9'b111000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic [2:0]  prog_sel5;
  logic [6:0]  pc;
  logic [8:0]  instr;

  logic        core_rst, pc_load, run_en, busy, done, timeout;
  logic [6:0]  pc_load_val, halt_pc;
  logic [11:0] cycle_count;

  logic        b_core_rst, b_pc_load, b_run_en, b_busy, b_done, b_timeout;
  logic [6:0]  b_pc_load_val, b_halt_pc;
  logic [11:0] b_cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_ctrl #(
    .TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (prog_sel),
    .pc          (pc),
    .instr       (instr),
    .core_rst    (core_rst),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .run_en      (run_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .halt_pc     (halt_pc)
  );

  // Five entry points, so prog_sel is 3 bits and values 5..7 are out of range.
  run_ctrl #(
    .NUM_PROGS (5),
    .PROG_BASE ({7'd120, 7'd96, 7'd64, 7'd32, 7'd0}),
    .TIMEOUT   (20)
  ) dut5 (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (prog_sel5),
    .pc          (pc),
    .instr       (instr),
    .core_rst    (b_core_rst),
    .pc_load     (b_pc_load),
    .pc_load_val (b_pc_load_val),
    .run_en      (b_run_en),
    .busy        (b_busy),
    .done        (b_done),
    .timeout     (b_timeout),
    .cycle_count (b_cycle_count),
    .halt_pc     (b_halt_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns in the LOAD cycle.
  task automatic do_launch(input logic [1:0] s4, input logic [2:0] s5);
    start = 1'b1;
    step();
    start     = 1'b0;
    prog_sel  = s4;
    prog_sel5 = s5;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; prog_sel = '0; prog_sel5 = '0; pc = '0; instr = '0;
    step();
    step();
    check_eq("rst_core_rst", 32'(core_rst), 32'd1);
    check_eq("rst_pc_load", 32'(pc_load), 32'd0);
    check_eq("rst_run_en", 32'(run_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_cycle_count", 32'(cycle_count), 32'd0);
    check_eq("rst_halt_pc", 32'(halt_pc), 32'd0);
    check_eq("rst_pc_load_val", 32'(pc_load_val), 32'd0);
    reset = 1'b0;
    step();
    check_eq("idle_core_rst", 32'(core_rst), 32'd0);

    // Launch entry 2 after a 3-cycle start pulse, then halt at 66.
    start = 1'b1;
    step(); step(); step();
    start = 1'b0; prog_sel = 2'd2; prog_sel5 = 3'd4;
    step();
    check_eq("load_core_rst", 32'(core_rst), 32'd1);
    check_eq("load_pc_load", 32'(pc_load), 32'd1);
    check_eq("load_val_64", 32'(pc_load_val), 32'd64);
    check_eq("load_run_en", 32'(run_en), 32'd0);
    check_eq("load_busy", 32'(busy), 32'd1);
    check_eq("load5_val_120", 32'(b_pc_load_val), 32'd120);
    step();
    check_eq("run_run_en", 32'(run_en), 32'd1);
    check_eq("run_busy", 32'(busy), 32'd1);
    check_eq("run_core_rst", 32'(core_rst), 32'd0);
    check_eq("run_pc_load", 32'(pc_load), 32'd0);
    pc = 7'd64; step();
    pc = 7'd65; step();
    pc = 7'd66; instr = HaltInstr; step();
    instr = '0;
    check_eq("halt_done", 32'(done), 32'd1);
    check_eq("halt_pc", 32'(halt_pc), 32'd66);
    check_eq("halt_cycles", 32'(cycle_count), 32'd3);
    check_eq("halt_run_en", 32'(run_en), 32'd0);
    check_eq("halt_busy", 32'(busy), 32'd0);
    check_eq("halt_timeout", 32'(timeout), 32'd0);

    // PC sticks at 70 from the 4th RUN cycle; stall hits on the 6th.
    do_launch(2'd0, 3'd5);
    check_eq("stall_load_val", 32'(pc_load_val), 32'd0);
    check_eq("clamp5_sel5", 32'(b_pc_load_val), 32'd0);
    check_eq("stall_load_done_clr", 32'(done), 32'd0);
    step();
    pc = 7'd67; step();
    pc = 7'd68; step();
    pc = 7'd69; step();
    pc = 7'd70; step();
    check_eq("stall_c5_busy", 32'(busy), 32'd1);
    step();
    check_eq("stall_c6_busy", 32'(busy), 32'd1);
    check_eq("stall_c6_cycles", 32'(cycle_count), 32'd5);
    step();
    check_eq("stall_done", 32'(done), 32'd1);
    check_eq("stall_halt_pc", 32'(halt_pc), 32'd70);
    check_eq("stall_timeout", 32'(timeout), 32'd0);
    check_eq("stall_cycles", 32'(cycle_count), 32'd6);

    // Incrementing PC, no halt: watchdog fires after 20 RUN cycles.
    do_launch(2'd3, 3'd1);
    check_eq("tout_load_val", 32'(pc_load_val), 32'd96);
    check_eq("tout5_load_val", 32'(b_pc_load_val), 32'd32);
    step();
    for (int k = 0; k < 20; k++) begin
      pc = 7'(96 + k);
      if (k == 19) begin
        check_eq("tout_c20_busy", 32'(busy), 32'd1);
        check_eq("tout_c20_cycles", 32'(cycle_count), 32'd19);
      end
      step();
    end
    check_eq("tout_timeout", 32'(timeout), 32'd1);
    check_eq("tout_done", 32'(done), 32'd0);
    check_eq("tout_cycles", 32'(cycle_count), 32'd20);
    check_eq("tout_halt_pc", 32'(halt_pc), 32'd115);
    check_eq("tout_run_en", 32'(run_en), 32'd0);

    // Relaunch with entry 1 during RUN cycle 5.
    do_launch(2'd2, 3'd2);
    check_eq("rl_load_tout_clr", 32'(timeout), 32'd0);
    check_eq("rl_load_val_64", 32'(pc_load_val), 32'd64);
    step();
    pc = 7'd64; step();
    pc = 7'd65; step();
    pc = 7'd66; step();
    pc = 7'd67; start = 1'b1; step();
    pc = 7'd68; start = 1'b0; prog_sel = 2'd1; step();
    check_eq("rl_pc_load", 32'(pc_load), 32'd1);
    check_eq("rl_load_val_32", 32'(pc_load_val), 32'd32);
    check_eq("rl_load_cycles", 32'(cycle_count), 32'd5);
    check_eq("rl_load_done", 32'(done), 32'd0);
    check_eq("rl_load_timeout", 32'(timeout), 32'd0);
    check_eq("rl_load_halt_pc", 32'(halt_pc), 32'd0);
    step();
    check_eq("rl_run_cycles0", 32'(cycle_count), 32'd0);
    check_eq("rl_run_en", 32'(run_en), 32'd1);
    check_eq("rl_run_done", 32'(done), 32'd0);
    pc = 7'd32; step();
    check_eq("rl_run_cycles1", 32'(cycle_count), 32'd1);

    // Synchronous reset in the middle of RUN.
    reset = 1'b1; step();
    check_eq("mrst_core_rst", 32'(core_rst), 32'd1);
    check_eq("mrst_run_en", 32'(run_en), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_pc_load", 32'(pc_load), 32'd0);
    check_eq("mrst_pc_load_val", 32'(pc_load_val), 32'd0);
    check_eq("mrst_cycles", 32'(cycle_count), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    reset = 1'b0; step();
    check_eq("mrst_idle_core_rst", 32'(core_rst), 32'd0);
    check_eq("mrst_idle_busy", 32'(busy), 32'd0);

    // Out-of-range select on the five-entry instance falls back to entry 0.
    do_launch(2'd1, 3'd7);
    check_eq("clamp_dut_val", 32'(pc_load_val), 32'd32);
    check_eq("clamp7_val", 32'(b_pc_load_val), 32'd0);
    check_eq("clamp7_pc_load", 32'(b_pc_load), 32'd1);
    step();
    check_eq("clamp_run_en", 32'(run_en), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Parametrised run/launch controller for the single-cycle 9-bit core. Sequences each program run:
- launches on the falling edge of start, choosing one of NUM_PROGS entry points;
- holds the core in reset for one load cycle, then enables execution;
- detects halt opcode, PC stall or timeout, and reports done/timeout plus cycle count and halt PC.

Sits between the bench/top-level and the program counter, register file and data memory enables.

Parameters:
PC_W, 7, program counter width
INSTR_W, 9, instruction width
NUM_PROGS, 4, number of selectable program entry points (>=1)
PROG_BASE, {7'd96,7'd64,7'd32,7'd0}, packed NUM_PROGS*PC_W entry addresses; entry i at bits [i*PC_W +: PC_W]
CNT_W, 12, cycle counter width
TIMEOUT, 2000, run-cycle limit before abort (1..2^CNT_W-1)
HALT_OP, 9'b111000000, halt encoding
HALT_MASK, 9'b111111111, bits compared for halt
STALL_CYCLES, 2, consecutive same-PC run cycles that count as halted (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  launch request; run begins on its falling edge
prog_sel  in  max(1,$clog2(NUM_PROGS))  entry-point select, sampled on the start falling edge
pc  in  PC_W  current core PC
instr  in  INSTR_W  current fetched instruction
core_rst  out  1  core reset (reset OR LOAD state)
pc_load  out  1  PC load strobe
pc_load_val  out  PC_W  PC load value
run_en  out  1  core execute/write enable
busy  out  1  LOAD or RUN
done  out  1  level; run ended normally
timeout  out  1  level; run aborted by watchdog
cycle_count  out  CNT_W  RUN cycles in current/last run
halt_pc  out  PC_W  PC at which run ended

Behaviour:
- States: IDLE, LOAD, RUN, DONE, TOUT.
- Reset: state IDLE; start_q, done, timeout, busy, run_en, pc_load = 0; cycle_count, halt_pc, pc_load_val, stall counter = 0. core_rst = 1 while reset is high.
- Launch event: start_q==1 && start==0, where start_q is start registered every cycle.
  - In any non-reset state, launch forces the next state to LOAD. A mid-RUN launch aborts and relaunches.
  - sel_q <= prog_sel at launch. prog_sel >= NUM_PROGS selects entry 0.
- LOAD (exactly 1 cycle):
  - core_rst=1, pc_load=1, pc_load_val=PROG_BASE[sel_q], run_en=0, busy=1.
  - cycle_count, stall counter, done, timeout and halt_pc are cleared.
  - Next state: RUN.
- RUN:
  - run_en=1, busy=1.
  - cycle_count increments each cycle.
  - prev_pc <= pc. The stall counter increments when pc==prev_pc and resets to 0 otherwise. No comparison is made on the first RUN cycle.
- Exit conditions, evaluated in RUN, priority halt > stall > timeout:
  - halt: (instr & HALT_MASK) == (HALT_OP & HALT_MASK) -> DONE.
  - stall: stall counter reaches STALL_CYCLES-1 and pc==prev_pc -> DONE.
  - timeout: cycle_count == TIMEOUT-1 -> TOUT.
  - On the exit cycle, halt_pc <= pc. cycle_count includes the exit cycle.
- DONE: done=1, run_en=0, busy=0. Outputs hold until next launch.
- TOUT: timeout=1, otherwise the same as DONE. done and timeout are never both 1.
- IDLE: all outputs 0. A launch moves to LOAD.
- pc_load_val is registered. It holds the last loaded value outside LOAD.
- cycle_count never wraps, because TIMEOUT < 2^CNT_W.

Decomposition:
- Package run_ctrl_pkg holds:
  - state enum run_state_e {IDLE, LOAD, RUN, DONE, TOUT};
  - function entry_addr(base_vec, sel) that returns the PC_W slice.
- One sub-module, run_ctrl_watchdog:
  - contains the cycle counter, prev_pc/stall counter and timeout compare;
  - inputs: clr, en, pc;
  - outputs: stall_hit, tout_hit, cycle_count.
- The FSM, launch detect and halt decode stay in run_ctrl.

Test Plan:
- Reset, then start 1 for 3 cycles, then 0 with prog_sel=2:
  - next cycle core_rst=1, pc_load=1, pc_load_val=64;
  - following cycle run_en=1, busy=1.
- Run a pc sequence 64,65,66 with instr=9'b111000000 at 66 -> done=1 one cycle later, halt_pc=66, cycle_count=3, run_en=0.
- Run with pc stuck at 70 from the 4th RUN cycle, STALL_CYCLES=2 -> done=1, halt_pc=70, timeout=0.
- TIMEOUT=20, pc incrementing, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20, done=0.
- Launch again mid-RUN (cycle 5) with prog_sel=1:
  - LOAD with pc_load_val=32;
  - cycle_count restarts from 0;
  - done/timeout stay 0.
- Assert reset during RUN -> next cycle all outputs 0, state IDLE. Launch with prog_sel=7 (clamped) -> pc_load_val=0.
